// File: rtl/pipe_operand_feeder.sv
// Operand feeder for the pipelined MAC: local IF and filter scratchpads, streamed
// window by window as (if, filter) pairs over a valid/ready handshake.
module pipe_operand_feeder #(
    parameter int IF_CELL_SIZE     = 8,
    parameter int FILTER_CELL_SIZE = 8,
    parameter int IF_DEPTH         = 16,
    parameter int FILTER_SIZE      = 4,
    parameter int STRIDE           = 1,
    parameter int ADDR_W           = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_start,
    input  logic                        i_if_wr_en,
    input  logic [ADDR_W-1:0]           i_if_wr_addr,
    input  logic [IF_CELL_SIZE-1:0]     i_if_wr_data,
    input  logic                        i_filt_wr_en,
    input  logic [ADDR_W-1:0]           i_filt_wr_addr,
    input  logic [FILTER_CELL_SIZE-1:0] i_filt_wr_data,
    input  logic                        i_mac_ready,
    output logic [IF_CELL_SIZE-1:0]     o_if_out,
    output logic [FILTER_CELL_SIZE-1:0] o_filter_out,
    output logic                        o_can_mult,
    output logic                        o_par_done,
    output logic                        o_busy,
    output logic                        o_done
);

    localparam int NUM_WIN = (IF_DEPTH - FILTER_SIZE) / STRIDE + 1;
    localparam int MEM_D   = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_K   = ADDR_W'(FILTER_SIZE - 1);
    localparam logic [ADDR_W-1:0] LAST_W   = ADDR_W'(NUM_WIN - 1);
    localparam logic [ADDR_W-1:0] STRIDE_C = ADDR_W'(STRIDE);

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_DONE} state_t;

    state_t                      r_state;
    state_t                      w_stateNext;
    logic [ADDR_W-1:0]           r_w;
    logic [ADDR_W-1:0]           r_k;
    logic [ADDR_W-1:0]           w_wNext;
    logic [ADDR_W-1:0]           w_kNext;
    logic [ADDR_W-1:0]           w_addr;
    logic [IF_CELL_SIZE-1:0]     r_ifOut;
    logic [IF_CELL_SIZE-1:0]     w_ifOutNext;
    logic [FILTER_CELL_SIZE-1:0] r_filtOut;
    logic [FILTER_CELL_SIZE-1:0] w_filtOutNext;
    logic                        r_canMult;
    logic                        w_canMultNext;
    logic                        r_parDone;
    logic                        w_parDoneNext;
    logic                        r_busy;
    logic                        r_done;
    logic                        w_anyWrite;
    logic                        w_transfer;

    // Entries past the valid depth are never written or read; sizing to the full
    // address space keeps the index width exact.
    logic [IF_CELL_SIZE-1:0]     r_ifMem   [MEM_D];
    logic [FILTER_CELL_SIZE-1:0] r_filtMem [MEM_D];

    assign w_anyWrite = i_if_wr_en | i_filt_wr_en;
    assign w_transfer = r_canMult & i_mac_ready;

    always_ff @(posedge clk) begin
        if (r_state == S_IDLE) begin
            if (i_if_wr_en && (32'(i_if_wr_addr) < IF_DEPTH))
                r_ifMem[i_if_wr_addr] <= i_if_wr_data;
            if (i_filt_wr_en && (32'(i_filt_wr_addr) < FILTER_SIZE))
                r_filtMem[i_filt_wr_addr] <= i_filt_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_w       <= '0;
            r_k       <= '0;
            r_ifOut   <= '0;
            r_filtOut <= '0;
            r_canMult <= 1'b0;
            r_parDone <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_w       <= w_wNext;
            r_k       <= w_kNext;
            r_ifOut   <= w_ifOutNext;
            r_filtOut <= w_filtOutNext;
            r_canMult <= w_canMultNext;
            r_parDone <= w_parDoneNext;
            r_busy    <= (w_stateNext != S_IDLE);
            r_done    <= (w_stateNext == S_DONE);
        end
    end

    // The next pair is fetched on the same edge as the transfer, so the stream
    // runs without bubbles while the MAC keeps accepting.
    always_comb begin
        w_stateNext   = r_state;
        w_wNext       = r_w;
        w_kNext       = r_k;
        w_addr        = '0;
        w_ifOutNext   = r_ifOut;
        w_filtOutNext = r_filtOut;
        w_canMultNext = r_canMult;
        w_parDoneNext = r_parDone;
        case (r_state)
            S_IDLE: begin
                if (i_start && !w_anyWrite) begin
                    w_stateNext   = S_FEED;
                    w_wNext       = '0;
                    w_kNext       = '0;
                    w_ifOutNext   = r_ifMem[0];
                    w_filtOutNext = r_filtMem[0];
                    w_canMultNext = 1'b1;
                    w_parDoneNext = (LAST_K == '0);
                end
            end
            S_FEED: begin
                if (w_transfer) begin
                    if (r_w == LAST_W && r_k == LAST_K) begin
                        w_stateNext   = S_DONE;
                        w_canMultNext = 1'b0;
                        w_parDoneNext = 1'b0;
                    end else begin
                        if (r_k == LAST_K) begin
                            w_kNext = '0;
                            w_wNext = r_w + 1'b1;
                        end else begin
                            w_kNext = r_k + 1'b1;
                        end
                        w_addr        = w_wNext * STRIDE_C + w_kNext;
                        w_ifOutNext   = r_ifMem[w_addr];
                        w_filtOutNext = r_filtMem[w_kNext];
                        w_parDoneNext = (w_kNext == LAST_K);
                    end
                end
            end
            S_DONE: begin
                w_stateNext = S_IDLE;
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    assign o_if_out     = r_ifOut;
    assign o_filter_out = r_filtOut;
    assign o_can_mult   = r_canMult;
    assign o_par_done   = r_parDone;
    assign o_busy       = r_busy;
    assign o_done       = r_done;

endmodule

// File: tb/tb_pipe_operand_feeder.sv
// Self-checking bench for pipe_operand_feeder: scratchpad loads, streamed runs under
// several back-pressure patterns, ignored starts/writes, and mid-run reset.
module tb_pipe_operand_feeder;

    localparam int IFW     = 8;
    localparam int FW      = 8;
    localparam int DEPTH   = 16;
    localparam int FSIZE   = 4;
    localparam int STRIDE  = 1;
    localparam int AW      = 4;
    localparam int NUM_WIN = (DEPTH - FSIZE) / STRIDE + 1;
    localparam int TOTAL   = NUM_WIN * FSIZE;

    logic           clk = 1'b0;
    logic           rst;
    logic           i_start;
    logic           i_if_wr_en;
    logic [AW-1:0]  i_if_wr_addr;
    logic [IFW-1:0] i_if_wr_data;
    logic           i_filt_wr_en;
    logic [AW-1:0]  i_filt_wr_addr;
    logic [FW-1:0]  i_filt_wr_data;
    logic           i_mac_ready;
    logic [IFW-1:0] o_if_out;
    logic [FW-1:0]  o_filter_out;
    logic           o_can_mult;
    logic           o_par_done;
    logic           o_busy;
    logic           o_done;

    int total = 0;
    int bad   = 0;

    logic [IFW-1:0] mIf   [DEPTH];
    logic [FW-1:0]  mFilt [FSIZE];

    pipe_operand_feeder #(
        .IF_CELL_SIZE(IFW), .FILTER_CELL_SIZE(FW), .IF_DEPTH(DEPTH),
        .FILTER_SIZE(FSIZE), .STRIDE(STRIDE), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .i_start(i_start),
        .i_if_wr_en(i_if_wr_en), .i_if_wr_addr(i_if_wr_addr), .i_if_wr_data(i_if_wr_data),
        .i_filt_wr_en(i_filt_wr_en), .i_filt_wr_addr(i_filt_wr_addr), .i_filt_wr_data(i_filt_wr_data),
        .i_mac_ready(i_mac_ready),
        .o_if_out(o_if_out), .o_filter_out(o_filter_out), .o_can_mult(o_can_mult),
        .o_par_done(o_par_done), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkIdleZero(input string tag);
        checkOutput({tag, "_can_mult"}, 32'(o_can_mult), 32'd0);
        checkOutput({tag, "_par_done"}, 32'(o_par_done), 32'd0);
        checkOutput({tag, "_busy"},     32'(o_busy),     32'd0);
        checkOutput({tag, "_done"},     32'(o_done),     32'd0);
    endtask

    // Drives one cycle of scratchpad writes (and optionally start) from IDLE,
    // mirroring the writes that should land into the reference scratchpads.
    task automatic applyStimulus(input logic ifEn, input int ifA, input logic [IFW-1:0] ifD,
                                 input logic fEn, input int fA, input logic [FW-1:0] fD,
                                 input logic st);
        i_if_wr_en     = ifEn;
        i_if_wr_addr   = AW'(ifA);
        i_if_wr_data   = ifD;
        i_filt_wr_en   = fEn;
        i_filt_wr_addr = AW'(fA);
        i_filt_wr_data = fD;
        i_start        = st;
        @(negedge clk);
        if (ifEn && ifA < DEPTH) mIf[ifA] = ifD;
        if (fEn && fA < FSIZE) mFilt[fA] = fD;
        i_if_wr_en   = 1'b0;
        i_filt_wr_en = 1'b0;
        i_start      = 1'b0;
    endtask

    // mode 0: always ready; 1: ready every third cycle; 2: random ready.
    // disturb pulses start and writes while busy; abortAt >= 0 resets at that pair.
    task automatic runFeed(input int mode, input bit disturb, input int abortAt);
        int  n   = 0;
        int  cyc = 0;
        int  w;
        int  k;
        logic rdy;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        cyc = 1;
        while (n < TOTAL && cyc < 400) begin
            w = n / FSIZE;
            k = n % FSIZE;
            checkOutput("pair_valid",  32'(o_can_mult),   32'd1);
            checkOutput("pair_if",     32'(o_if_out),     32'(mIf[w * STRIDE + k]));
            checkOutput("pair_filter", 32'(o_filter_out), 32'(mFilt[k]));
            checkOutput("pair_last",   32'(o_par_done),   32'(k == FSIZE - 1));
            checkOutput("feed_busy",   32'(o_busy),       32'd1);
            checkOutput("feed_done",   32'(o_done),       32'd0);
            if (abortAt >= 0 && n == abortAt) begin
                rst = 1'b1;
                #1;
                checkIdleZero("abort_async");
                checkOutput("abort_if",     32'(o_if_out),     32'd0);
                checkOutput("abort_filter", 32'(o_filter_out), 32'd0);
                @(negedge clk);
                rst = 1'b0;
                i_mac_ready = 1'b0;
                @(negedge clk);
                checkIdleZero("abort_after");
                return;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 1);
                default: rdy = ($urandom_range(0, 99) < 60);
            endcase
            i_mac_ready = rdy;
            if (disturb) begin
                i_start        = 1'($urandom_range(0, 1));
                i_if_wr_en     = 1'($urandom_range(0, 1));
                i_if_wr_addr   = AW'($urandom_range(0, DEPTH - 1));
                i_if_wr_data   = IFW'($urandom);
                i_filt_wr_en   = 1'($urandom_range(0, 1));
                i_filt_wr_addr = AW'($urandom_range(0, FSIZE - 1));
                i_filt_wr_data = FW'($urandom);
            end
            @(negedge clk);
            cyc++;
            if (rdy) n++;
        end
        i_start      = 1'b0;
        i_if_wr_en   = 1'b0;
        i_filt_wr_en = 1'b0;
        i_mac_ready  = 1'b0;
        if (cyc >= 400) begin
            total++;
            bad++;
            $error("[TB] FAIL run_timeout observed=%0d pairs expected=%0d", n, TOTAL);
        end
        checkOutput("end_done",     32'(o_done),     32'd1);
        checkOutput("end_busy",     32'(o_busy),     32'd1);
        checkOutput("end_can_mult", 32'(o_can_mult), 32'd0);
        checkOutput("end_par_done", 32'(o_par_done), 32'd0);
        if (mode == 0) checkOutput("latency", 32'(cyc), 32'(TOTAL + 1));
        i_start = disturb;
        @(negedge clk);
        i_start = 1'b0;
        checkIdleZero("post_run");
        @(negedge clk);
        checkIdleZero("post_run2");
    endtask

    initial begin
        rst            = 1'b1;
        i_start        = 1'b0;
        i_if_wr_en     = 1'b0;
        i_if_wr_addr   = '0;
        i_if_wr_data   = '0;
        i_filt_wr_en   = 1'b0;
        i_filt_wr_addr = '0;
        i_filt_wr_data = '0;
        i_mac_ready    = 1'b0;
        repeat (2) @(negedge clk);
        checkIdleZero("reset");
        checkOutput("reset_if",     32'(o_if_out),     32'd0);
        checkOutput("reset_filter", 32'(o_filter_out), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkIdleZero("reset_release");

        $display("[TB] directed load and full-rate run");
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, i, IFW'(i + 1), 1'b0, 0, '0, 1'b0);
        for (int i = 0; i < FSIZE; i++) applyStimulus(1'b0, 0, '0, 1'b1, i, FW'(8'h10 + i), 1'b0);
        applyStimulus(1'b0, 0, '0, 1'b1, FSIZE + 2, 8'hEE, 1'b0);
        runFeed(0, 1'b0, -1);

        $display("[TB] stalled run");
        runFeed(1, 1'b0, -1);

        $display("[TB] random back-pressure with ignored starts and writes");
        runFeed(2, 1'b1, -1);
        runFeed(0, 1'b0, -1);

        $display("[TB] random scratchpad contents");
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, i, IFW'($urandom), 1'b0, 0, '0, 1'b0);
        for (int i = 0; i < FSIZE; i++) applyStimulus(1'b0, 0, '0, 1'b1, i, FW'($urandom), 1'b0);
        runFeed(2, 1'b0, -1);

        $display("[TB] start colliding with a write");
        applyStimulus(1'b1, 0, 8'hA5, 1'b0, 0, '0, 1'b1);
        checkIdleZero("start_with_write");
        runFeed(0, 1'b0, -1);

        $display("[TB] reset mid-run then restart");
        runFeed(0, 1'b0, 20);
        runFeed(0, 1'b0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
